// File: rtl/memory_image_loader.sv
// Stream loader for the relay computer's program memory: collects a byte
// image plus checksum over valid/ready, verifies it and hands it over.
// Ports:
//   clock, reset (async, active-low)
//   start: begin a new image (ignored while loading)
//   byte_in/byte_valid/byte_ready: byte stream handshake
//   initial_memory: assembled image, stream byte k at index k
//   loadMem/loadMemComplete: copy request to the computer and its ack
//   busy, done, error: status; done/error are sticky until next start
module memory_image_loader #(
   parameter int DEPTH   = 15,
   parameter int WIDTH   = 8,
   parameter int TIMEOUT = 255
) (
   input  logic                         clock,
   input  logic                         reset,
   input  logic                         start,
   input  logic [WIDTH-1:0]             byte_in,
   input  logic                         byte_valid,
   output logic                         byte_ready,
   output logic [DEPTH-1:0][WIDTH-1:0]  initial_memory,
   output logic                         loadMem,
   input  logic                         loadMemComplete,
   output logic                         busy,
   output logic                         done,
   output logic                         error
);

   localparam int CW = $clog2(DEPTH + 1);
   localparam int TW = $clog2(TIMEOUT + 1);
   localparam logic [CW-1:0] LAST  = CW'(DEPTH - 1);
   localparam logic [TW-1:0] TLAST = TW'(TIMEOUT - 1);

   typedef enum logic [2:0] {
      IDLE, RECV, CHECK, LOAD, DONE, ERR
   } state_t;

   state_t           state;
   logic [CW-1:0]    count;
   logic [WIDTH-1:0] sum;
   logic [WIDTH-1:0] sum_next;
   logic [TW-1:0]    timer;
   logic             xfer;

   assign xfer     = byte_valid && byte_ready;
   assign sum_next = sum + byte_in;

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state          <= IDLE;
         initial_memory <= '0;
         count          <= '0;
         sum            <= '0;
         timer          <= '0;
         byte_ready     <= 1'b0;
         loadMem        <= 1'b0;
         busy           <= 1'b0;
         done           <= 1'b0;
         error          <= 1'b0;
      end else if (start && state != LOAD) begin
         // Fresh image from any non-LOAD state; a byte offered on
         // this edge is dropped.
         state          <= RECV;
         initial_memory <= '0;
         count          <= '0;
         sum            <= '0;
         timer          <= '0;
         byte_ready     <= 1'b1;
         loadMem        <= 1'b0;
         busy           <= 1'b1;
         done           <= 1'b0;
         error          <= 1'b0;
      end else begin
         unique case (state)
            RECV: begin
               if (xfer) begin
                  initial_memory[count] <= byte_in;
                  sum                   <= sum_next;
                  count                 <= count + CW'(1);
                  if (count == LAST) state <= CHECK;
               end
            end
            CHECK: begin
               // Checksum byte only folds into the sum; not stored.
               if (xfer) begin
                  byte_ready <= 1'b0;
                  if (sum_next == '0) begin
                     state   <= LOAD;
                     loadMem <= 1'b1;
                     timer   <= '0;
                  end else begin
                     state <= ERR;
                     busy  <= 1'b0;
                     error <= 1'b1;
                  end
               end
            end
            LOAD: begin
               // Ack wins over a timeout on the same edge.
               if (loadMemComplete) begin
                  state   <= DONE;
                  loadMem <= 1'b0;
                  busy    <= 1'b0;
                  done    <= 1'b1;
               end else if (timer == TLAST) begin
                  state   <= ERR;
                  loadMem <= 1'b0;
                  busy    <= 1'b0;
                  error   <= 1'b1;
               end else begin
                  timer <= timer + TW'(1);
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_memory_image_loader.sv
// Self-checking bench for memory_image_loader: table vectors, hand
// sequences for abort/reset, and random images against a result model.
module tb_memory_image_loader;

   localparam int TMO = 255;

   logic             clock;
   logic             reset;
   logic             start;
   logic [7:0]       byte_in;
   logic             byte_valid;
   logic             byte_ready;
   logic [14:0][7:0] mem;
   logic             loadMem;
   logic             loadMemComplete;
   logic             busy;
   logic             done;
   logic             error;

   int n_cmp = 0;
   int n_bad = 0;

   memory_image_loader #(
      .DEPTH(15), .WIDTH(8), .TIMEOUT(TMO)
   ) dut (
      .clock          (clock),
      .reset          (reset),
      .start          (start),
      .byte_in        (byte_in),
      .byte_valid     (byte_valid),
      .byte_ready     (byte_ready),
      .initial_memory (mem),
      .loadMem        (loadMem),
      .loadMemComplete(loadMemComplete),
      .busy           (busy),
      .done           (done),
      .error          (error)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   typedef struct {
      logic [7:0] base;
      logic [7:0] chk;
      int         gap;
      int         ack;
      bit         sil;
      bit         e_done;
      bit         e_err;
      int         e_lm;
      logic [7:0] e_m0;
      logic [7:0] e_m14;
   } vec_t;

   vec_t tbl[9];

   task automatic step();
      @(posedge clock);
      #1;
   endtask

   task automatic check(input string nm, input logic [127:0] act,
                        input logic [127:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   // Result expected from the image's rules alone.
   function automatic void model(input logic [14:0][7:0] img,
                                 input logic [7:0] chk, input int ack,
                                 output bit d, output bit e,
                                 output int lm);
      int s;
      s = chk;
      for (int k = 0; k < 15; k++) s += img[k];
      if (s % 256 != 0) begin
         d = 0; e = 1; lm = 0;
      end else if (ack >= 1 && ack <= TMO) begin
         d = 1; e = 0; lm = ack;
      end else begin
         d = 0; e = 1; lm = TMO;
      end
   endfunction

   // Pulse start (with a junk byte that must be dropped), then send
   // 15 bytes and the checksum; gap<0 means random idle cycles.
   task automatic feed(input logic [14:0][7:0] img, input logic [7:0] chk,
                       input int gap, output bit rdy_ok);
      int g;
      start = 1; byte_valid = 1; byte_in = 8'($urandom);
      step();
      start = 0; byte_valid = 0;
      rdy_ok = 1;
      for (int i = 0; i < 16; i++) begin
         g = (gap < 0) ? int'($urandom_range(0, 2)) : gap;
         for (int j = 0; j < g; j++) begin
            byte_valid = 0; byte_in = 8'($urandom);
            step();
         end
         if (byte_ready !== 1'b1) rdy_ok = 0;
         byte_valid = 1;
         byte_in = (i < 15) ? img[i] : chk;
         step();
      end
      byte_valid = 0;
   endtask

   task automatic run_image(input string nm, input logic [14:0][7:0] img,
                            input logic [7:0] chk, input int gap,
                            input int ack, input bit sil,
                            input bit e_done, input bit e_err,
                            input int e_lm);
      bit rdy_ok;
      bit ld_ok;
      bit fin;
      int lm;
      int cyc;
      feed(img, chk, gap, rdy_ok);
      lm = 0; cyc = 0; ld_ok = 1; fin = 0;
      while (!fin && cyc < 400) begin
         if (loadMem) begin
            lm++;
            if (byte_ready !== 1'b0 || busy !== 1'b1) ld_ok = 0;
         end
         if (done || error) begin
            fin = 1;
         end else begin
            loadMemComplete = loadMem && (lm == ack);
            start = sil && loadMem && (lm == 2);
            byte_valid = 1'($urandom);
            byte_in = 8'($urandom);
            step();
         end
         cyc++;
      end
      start = 0; byte_valid = 0; loadMemComplete = 0;
      if (!fin) begin
         n_cmp++; n_bad++;
         $display("FAIL %s.timeout: got no done/error expected end", nm);
      end
      check({nm, ".image"}, 128'(mem), 128'(img));
      check({nm, ".done"}, 128'(done), 128'(e_done));
      check({nm, ".error"}, 128'(error), 128'(e_err));
      check({nm, ".lm_cycles"}, 128'(lm), 128'(e_lm));
      check({nm, ".rdy_stream"}, 128'(rdy_ok), 128'(1));
      check({nm, ".load_flags"}, 128'(ld_ok), 128'(1));
      check({nm, ".busy_end"}, 128'(busy), 128'(0));
   endtask

   function automatic logic [14:0][7:0] ramp(input logic [7:0] base);
      logic [14:0][7:0] r;
      for (int k = 0; k < 15; k++) r[k] = base + 8'(k);
      return r;
   endfunction

   initial begin
      logic [14:0][7:0] img;
      logic [7:0] chk;
      bit rdy_ok;
      bit d, e;
      int lm, ack, r, s;

      tbl[0] = '{8'h01, 8'h88, 0, 3,   1'b0, 1'b1, 1'b0, 3,   8'h01, 8'h0F};
      tbl[1] = '{8'h01, 8'h87, 0, 3,   1'b0, 1'b0, 1'b1, 0,   8'h01, 8'h0F};
      tbl[2] = '{8'h01, 8'h88, 1, 3,   1'b0, 1'b1, 1'b0, 3,   8'h01, 8'h0F};
      tbl[3] = '{8'h01, 8'h88, 0, 0,   1'b0, 1'b0, 1'b1, 255, 8'h01, 8'h0F};
      tbl[4] = '{8'h01, 8'h88, 0, 255, 1'b0, 1'b1, 1'b0, 255, 8'h01, 8'h0F};
      tbl[5] = '{8'h01, 8'h88, 0, 5,   1'b1, 1'b1, 1'b0, 5,   8'h01, 8'h0F};
      tbl[6] = '{8'hF8, 8'h0F, -1, 1,  1'b0, 1'b1, 1'b0, 1,   8'hF8, 8'h06};
      tbl[7] = '{8'h00, 8'h97, 0, 254, 1'b0, 1'b1, 1'b0, 254, 8'h00, 8'h0E};
      tbl[8] = '{8'h00, 8'h98, 0, 2,   1'b0, 1'b0, 1'b1, 0,   8'h00, 8'h0E};

      reset = 0; start = 0; byte_in = 0; byte_valid = 0;
      loadMemComplete = 0;
      #22;
      check("rst.ready", 128'(byte_ready), 128'(0));
      check("rst.loadMem", 128'(loadMem), 128'(0));
      check("rst.flags", 128'({busy, done, error}), 128'(0));
      check("rst.image", 128'(mem), 128'(0));
      reset = 1;
      step();

      // Byte offered in IDLE without start: nothing happens.
      byte_valid = 1; byte_in = 8'h5A;
      step(); step();
      byte_valid = 0;
      check("idle.ignore", 128'({mem, busy, byte_ready}), 128'(0));

      for (int t = 0; t < 9; t++) begin
         img = ramp(tbl[t].base);
         run_image($sformatf("vec%0d", t), img, tbl[t].chk, tbl[t].gap,
                   tbl[t].ack, tbl[t].sil, tbl[t].e_done, tbl[t].e_err,
                   tbl[t].e_lm);
         check($sformatf("vec%0d.m0", t), 128'(mem[0]), 128'(tbl[t].e_m0));
         check($sformatf("vec%0d.m14", t), 128'(mem[14]),
               128'(tbl[t].e_m14));
      end

      // Abort after 7 bytes; the new stream must fully replace them.
      start = 1; step(); start = 0;
      for (int i = 0; i < 7; i++) begin
         byte_valid = 1; byte_in = 8'hEE; step();
      end
      byte_valid = 0;
      run_image("abort", ramp(8'h01), 8'h88, 0, 4, 1'b0, 1'b1, 1'b0, 4);

      // Async reset mid-RECV.
      start = 1; step(); start = 0;
      for (int i = 0; i < 5; i++) begin
         byte_valid = 1; byte_in = 8'h33; step();
      end
      byte_valid = 0;
      #2 reset = 0;
      #1;
      check("rstrecv.ready", 128'(byte_ready), 128'(0));
      check("rstrecv.all", 128'({mem, busy, done, error, loadMem}), 128'(0));
      reset = 1;
      step();

      // Async reset mid-LOAD.
      feed(ramp(8'h01), 8'h88, 0, rdy_ok);
      step(); step();
      check("midload.loadMem", 128'(loadMem), 128'(1));
      #2 reset = 0;
      #1;
      check("rstload.loadMem", 128'(loadMem), 128'(0));
      check("rstload.all", 128'({mem, busy, done, error, byte_ready}),
            128'(0));
      reset = 1;
      step();

      // Random images against the result model.
      for (int t = 0; t < 20; t++) begin
         s = 0;
         for (int k = 0; k < 15; k++) begin
            img[k] = 8'($urandom);
            s += img[k];
         end
         chk = 8'(256 - (s % 256));
         if ($urandom_range(0, 3) == 0) chk = chk + 8'($urandom_range(1, 255));
         r = $urandom_range(0, 9);
         if (r < 6)      ack = $urandom_range(1, 20);
         else if (r < 8) ack = $urandom_range(240, 260);
         else            ack = 0;
         model(img, chk, ack, d, e, lm);
         run_image($sformatf("rnd%0d", t), img, chk, -1, ack,
                   1'($urandom), d, e, lm);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
